// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Constants shared by the machine-mode trap logic: CSR addresses, the bit
// positions inside mstatus/mie/mip, the external-interrupt cause code and the
// trap sequencer state type.
// ---------------------------------------------------------------------------
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MIE_MEIE       = 11;
  localparam int MIP_MEIP       = 11;

  // Machine external interrupt cause code
  localparam int CAUSE_M_EXT = 11;

  // Vectored mode places each cause's entry 4 bytes apart
  localparam int VEC_OFFSET_M_EXT = CAUSE_M_EXT * 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_SAVE_STAT,
    ST_REDIR,
    ST_RESTORE,
    ST_RET
  } trap_state_e;

endpackage

// File: rtl/trap_drain_timer.sv
// ---------------------------------------------------------------------------
// trap_drain_timer
// Counts cycles spent waiting for the pipeline to drain and flags expiry.
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : return the count to zero (takes priority over en_i)
//   en_i      : count this cycle
//   expire_o  : this counting cycle is the TIMEOUT-th one (never when TIMEOUT=0)
// ---------------------------------------------------------------------------
module trap_drain_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CNT_W-1:0] count_q;

  // Cycle counter; with TIMEOUT=0 it simply wraps and expiry is masked off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Expiry is flagged in the cycle the count would reach TIMEOUT, so the
  // caller leaves the wait after exactly TIMEOUT enabled cycles.
  assign expire_o = (TIMEOUT != 0) && en_i && (count_q == CNT_W'(LAST));

endmodule

// File: rtl/trap_seq.sv
// ---------------------------------------------------------------------------
// trap_seq
// Machine-mode external-interrupt trap sequencer. Detects an enabled external
// interrupt, stalls and drains the pipeline, writes mepc/mcause/mstatus
// through the single CSR write port, then redirects fetch to mtvec. On mret
// it restores mstatus and redirects fetch to mepc.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   mstatus_i/mie_i/mip_i        current interrupt CSRs
//   mtvec_i, mepc_i              trap vector and return address CSRs
//   resume_pc_i                  PC of the oldest uncommitted instruction
//   pipe_empty_i                 nothing in flight past fetch
//   mret_i                       one-cycle pulse, mret committed
//   stall_o, flush_o             freeze fetch/issue, kill fetch stage
//   redir_valid_o/redir_pc_o     fetch redirect request (held until ready)
//   redir_ready_i                fetch accepts the redirect
//   csr_we_o/csr_waddr_o/_wdata_o  CSR write port
//   in_handler_o                 a trap is being serviced
//   drain_err_o                  sticky, drain timed out
//
// Build option: define TRAP_SEQ_VECTORED_EN to honour vectored mtvec mode
// (mode 2'b01 jumps to base + 44); otherwise the mode bits are ignored.
// ---------------------------------------------------------------------------
module trap_seq
  import csr_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ALEN          = 32,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mip_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [ALEN-1:0] resume_pc_i,
  input  logic            pipe_empty_i,
  input  logic            mret_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redir_valid_o,
  output logic [ALEN-1:0] redir_pc_o,
  input  logic            redir_ready_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            in_handler_o,
  output logic            drain_err_o
);

  trap_state_e     state_q;
  logic            stall_q;
  logic            redir_valid_q;
  logic [ALEN-1:0] redir_pc_q;
  logic            csr_we_q;
  logic [11:0]     csr_waddr_q;
  logic [XLEN-1:0] csr_wdata_q;
  logic            in_handler_q;
  logic            drain_err_q;

  logic            irq_take;
  logic            drain_expire;
  logic [XLEN-1:0] entry_mstatus;
  logic [XLEN-1:0] restore_mstatus;
  logic [XLEN-1:0] epc_wdata;
  logic [XLEN-1:0] cause_wdata;
  logic [ALEN-1:0] trap_base;
  logic [ALEN-1:0] trap_target;
  logic [ALEN-1:0] mepc_target;
  logic            unused_bits;

  assign irq_take = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MEIE] & mip_i[MIP_MEIP];

  // Only parts of several inputs are meaningful here.
  assign unused_bits = ^{mie_i, mip_i, mtvec_i, mepc_i, resume_pc_i};

  trap_drain_timer #(
    .TIMEOUT (DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != ST_DRAIN),
    .en_i     (state_q == ST_DRAIN),
    .expire_o (drain_expire)
  );

  // mstatus images written on trap entry and on mret.
  always_comb begin
    entry_mstatus                          = mstatus_i;
    entry_mstatus[MSTATUS_MPIE]            = mstatus_i[MSTATUS_MIE];
    entry_mstatus[MSTATUS_MIE]             = 1'b0;
    entry_mstatus[MSTATUS_MPP_LO +: 2]     = 2'b11;
    restore_mstatus                        = mstatus_i;
    restore_mstatus[MSTATUS_MIE]           = mstatus_i[MSTATUS_MPIE];
    restore_mstatus[MSTATUS_MPIE]          = 1'b1;
  end

  assign epc_wdata   = XLEN'({resume_pc_i[ALEN-1:2], 2'b00});
  assign cause_wdata = {1'b1, (XLEN-1)'(CAUSE_M_EXT)};
  assign trap_base   = {mtvec_i[ALEN-1:2], 2'b00};
  assign mepc_target = {mepc_i[ALEN-1:2], 2'b00};

`ifdef TRAP_SEQ_VECTORED_EN
  assign trap_target = (mtvec_i[1:0] == 2'b01) ? trap_base + ALEN'(VEC_OFFSET_M_EXT)
                                               : trap_base;
`else
  assign trap_target = trap_base;
`endif

  // Sequencer with registered outputs: every transition loads the outputs
  // belonging to the state being entered. The aligned resume PC is captured
  // straight into the CSR write-data register on the way into SAVE_EPC, which
  // is the single place the exception PC needs to live. Redirect target and
  // valid are loaded once on entry to REDIR/RET and therefore stay stable
  // until fetch accepts them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      stall_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      csr_we_q      <= 1'b0;
      csr_waddr_q   <= '0;
      csr_wdata_q   <= '0;
      in_handler_q  <= 1'b0;
      drain_err_q   <= 1'b0;
    end else begin
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // mret of an active handler takes precedence over a new interrupt;
          // while a handler runs, further interrupts are not taken.
          if (mret_i && in_handler_q) begin
            state_q     <= ST_RESTORE;
            stall_q     <= 1'b1;
            csr_we_q    <= 1'b1;
            csr_waddr_q <= CSR_MSTATUS;
            csr_wdata_q <= restore_mstatus;
          end else if (irq_take && !in_handler_q) begin
            state_q <= ST_DRAIN;
            stall_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!irq_take) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
          end else if (pipe_empty_i || drain_expire) begin
            if (!pipe_empty_i) begin
              drain_err_q <= 1'b1;
            end
            state_q     <= ST_SAVE_EPC;
            csr_we_q    <= 1'b1;
            csr_waddr_q <= CSR_MEPC;
            csr_wdata_q <= epc_wdata;
          end
        end
        ST_SAVE_EPC: begin
          state_q     <= ST_SAVE_CAUSE;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= CSR_MCAUSE;
          csr_wdata_q <= cause_wdata;
        end
        ST_SAVE_CAUSE: begin
          state_q     <= ST_SAVE_STAT;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= CSR_MSTATUS;
          csr_wdata_q <= entry_mstatus;
        end
        ST_SAVE_STAT: begin
          state_q       <= ST_REDIR;
          redir_valid_q <= 1'b1;
          redir_pc_q    <= trap_target;
        end
        ST_REDIR: begin
          if (redir_ready_i) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            stall_q       <= 1'b0;
            in_handler_q  <= 1'b1;
          end
        end
        ST_RESTORE: begin
          state_q       <= ST_RET;
          redir_valid_q <= 1'b1;
          redir_pc_q    <= mepc_target;
        end
        ST_RET: begin
          if (redir_ready_i) begin
            state_q       <= ST_IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            stall_q       <= 1'b0;
            in_handler_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The fetch kill must coincide with the accepting handshake cycle.
  assign flush_o = redir_valid_q & redir_ready_i;

  assign stall_o       = stall_q;
  assign redir_valid_o = redir_valid_q;
  assign redir_pc_o    = redir_pc_q;
  assign csr_we_o      = csr_we_q;
  assign csr_waddr_o   = csr_waddr_q;
  assign csr_wdata_o   = csr_wdata_q;
  assign in_handler_o  = in_handler_q;
  assign drain_err_o   = drain_err_q;

endmodule

// File: tb/tb_trap_seq.sv
// ---------------------------------------------------------------------------
// tb_trap_seq
// Scoreboard bench for trap_seq. Stimulus tasks push the CSR writes and
// redirect targets the trap rules predict; a negedge monitor pops and
// compares them whenever the DUT writes a CSR or presents a redirect.
// Honours TRAP_SEQ_VECTORED_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_trap_seq;

  localparam int XLEN = 32;
  localparam int ALEN = 32;
  localparam int TMO  = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] mstatus_i = '0;
  logic [XLEN-1:0] mie_i = '0;
  logic [XLEN-1:0] mip_i = '0;
  logic [XLEN-1:0] mtvec_i = '0;
  logic [XLEN-1:0] mepc_i = '0;
  logic [ALEN-1:0] resume_pc_i = '0;
  logic            pipe_empty_i = 1'b0;
  logic            mret_i = 1'b0;
  logic            redir_ready_i = 1'b0;
  logic            stall_o;
  logic            flush_o;
  logic            redir_valid_o;
  logic [ALEN-1:0] redir_pc_o;
  logic            csr_we_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            in_handler_o;
  logic            drain_err_o;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expWr[$];
  logic [31:0] expRedir[$];
  wr_t         monWr;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          flushSeen = 0;
  int          flushExp = 0;
  int          errSticky = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  trap_seq #(
    .XLEN          (XLEN),
    .ALEN          (ALEN),
    .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mstatus_i     (mstatus_i),
    .mie_i         (mie_i),
    .mip_i         (mip_i),
    .mtvec_i       (mtvec_i),
    .mepc_i        (mepc_i),
    .resume_pc_i   (resume_pc_i),
    .pipe_empty_i  (pipe_empty_i),
    .mret_i        (mret_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .redir_valid_o (redir_valid_o),
    .redir_pc_o    (redir_pc_o),
    .redir_ready_i (redir_ready_i),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .in_handler_o  (in_handler_o),
    .drain_err_o   (drain_err_o)
  );

  // Reference rules, written as arithmetic on the architectural fields.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return (pc / 4) * 4;
  endfunction

  function automatic logic [31:0] trapEntryStatus(input logic [31:0] ms);
    logic [31:0] oldMie;
    oldMie = (ms >> 3) % 2;
    return (ms & ~32'h0000_1888) + (oldMie * 128) + 32'h0000_1800;
  endfunction

  function automatic logic [31:0] mretStatus(input logic [31:0] ms);
    logic [31:0] oldMpie;
    oldMpie = (ms >> 7) % 2;
    return (ms & ~32'h0000_0088) + (oldMpie * 8) + 32'h0000_0080;
  endfunction

  function automatic logic [31:0] trapTarget(input logic [31:0] tv);
    logic [31:0] base;
    base = alignPc(tv);
`ifdef TRAP_SEQ_VECTORED_EN
    if (tv % 4 == 1) return base + 32'd44;
`endif
    return base;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Monitor: pops expected writes and redirect targets as the DUT shows them.
  always @(negedge clk) begin
    if (!rst) begin
      if (csr_we_o) begin
        if (expWr.size() == 0) begin
          reportFail("csr_unexpected_write", 32'(csr_waddr_o), 32'h0);
        end else begin
          monWr = expWr.pop_front();
          checkOutput("csr_waddr", 32'(csr_waddr_o), 32'(monWr.addr));
          checkOutput("csr_wdata", csr_wdata_o, monWr.data);
        end
      end
      if (redir_valid_o) begin
        if (expRedir.size() == 0) begin
          reportFail("redir_unexpected", redir_pc_o, 32'h0);
        end else begin
          checkOutput("redir_pc", redir_pc_o, expRedir[0]);
          if (redir_ready_i) begin
            checkOutput("flush_on_accept", 32'(flush_o), 32'd1);
            void'(expRedir.pop_front());
            flushSeen++;
          end
        end
      end else if (flush_o) begin
        reportFail("flush_without_redirect", 32'(flush_o), 32'd0);
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, "_flush"}, 32'(flush_o), 32'd0);
    checkOutput({tag, "_redir_valid"}, 32'(redir_valid_o), 32'd0);
    checkOutput({tag, "_redir_pc"}, redir_pc_o, 32'd0);
    checkOutput({tag, "_csr_we"}, 32'(csr_we_o), 32'd0);
    checkOutput({tag, "_csr_waddr"}, 32'(csr_waddr_o), 32'd0);
    checkOutput({tag, "_csr_wdata"}, csr_wdata_o, 32'd0);
    checkOutput({tag, "_in_handler"}, 32'(in_handler_o), 32'd0);
    checkOutput({tag, "_drain_err"}, 32'(drain_err_o), 32'd0);
  endtask

  // Holds ready low for r cycles of a visible redirect, then accepts it.
  task automatic waitRedirect(input int r);
    int  seen;
    bit  done;
    seen = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (redir_valid_o) begin
        if (seen == r) redir_ready_i = 1'b1;
        seen++;
      end else if (redir_ready_i) begin
        redir_ready_i = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      redir_ready_i = 1'b0;
      reportFail("redirect_timeout", 32'(seen), 32'(r + 1));
    end else begin
      checkOutput("redir_valid_cycles", 32'(seen), 32'(r + 1));
    end
  endtask

  // Raises an interrupt; pipe drains d cycles after the sequencer starts
  // waiting (d < 0: never, so the drain timeout fires).
  task automatic applyStimulus(input logic [31:0] ms, input logic [31:0] meV,
                               input logic [31:0] mpV, input logic [31:0] tv,
                               input logic [31:0] pc, input int d, input int r);
    int c0;
    int lat;
    bit seen;
    @(posedge clk); #1;
    mstatus_i    = ms;
    mie_i        = meV;
    mip_i        = mpV;
    mtvec_i      = tv;
    resume_pc_i  = pc;
    pipe_empty_i = 1'b0;
    c0 = cyc;
    expWr.push_back('{12'h341, alignPc(pc)});
    expWr.push_back('{12'h342, 32'h8000_000B});
    expWr.push_back('{12'h300, trapEntryStatus(ms)});
    expRedir.push_back(trapTarget(tv));
    flushExp++;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (cyc == c0 + 1) checkOutput("stall_in_drain", 32'(stall_o), 32'd1);
      if (d >= 0 && cyc >= c0 + 1 + d) pipe_empty_i = 1'b1;
      if (csr_we_o) begin
        seen = 1'b1;
        lat = cyc - c0;
      end
    end
    if (!seen) reportFail("first_write_timeout", 32'(lat), 32'd0);
    else checkOutput("entry_latency", 32'(lat), (d >= 0) ? 32'(2 + d) : 32'(1 + TMO));
    waitRedirect(r);
    if (d < 0) errSticky = 1;
    pipe_empty_i = 1'b0;
    checkOutput("in_handler_after_entry", 32'(in_handler_o), 32'd1);
    checkOutput("stall_after_entry", 32'(stall_o), 32'd0);
    checkOutput("flush_count", 32'(flushSeen), 32'(flushExp));
    checkOutput("drain_err", 32'(drain_err_o), 32'(errSticky));
    checkOutput("entry_writes_left", 32'(expWr.size()), 32'd0);
  endtask

  task automatic applyMret(input logic [31:0] ms, input logic [31:0] ep, input int r);
    @(posedge clk); #1;
    mip_i     = '0;
    mstatus_i = ms;
    mepc_i    = ep;
    mret_i    = 1'b1;
    expWr.push_back('{12'h300, mretStatus(ms)});
    expRedir.push_back(alignPc(ep));
    flushExp++;
    @(posedge clk); #1;
    mret_i = 1'b0;
    checkOutput("stall_in_restore", 32'(stall_o), 32'd1);
    waitRedirect(r);
    checkOutput("in_handler_after_mret", 32'(in_handler_o), 32'd0);
    checkOutput("stall_after_mret", 32'(stall_o), 32'd0);
    checkOutput("flush_count", 32'(flushSeen), 32'(flushExp));
    checkOutput("mret_writes_left", 32'(expWr.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ms, meV, mpV, tv, pc, ep;
    int          hit;

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1 checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed entry and return.
    applyStimulus(32'h8, 32'h800, 32'h800, 32'h1000, 32'h204, 3, 4);
    applyMret(32'h1880, 32'h204, 2);

    // Randomised entries and returns.
    for (int k = 0; k < 6; k++) begin
      ms  = $urandom | 32'h8;
      meV = $urandom | 32'h800;
      mpV = $urandom | 32'h800;
      tv  = $urandom;
      pc  = $urandom;
      applyStimulus(ms, meV, mpV, tv, pc, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      ms = $urandom;
      ep = $urandom;
      applyMret(ms, ep, int'($urandom_range(0, 4)));
    end

    // mret outside a handler is ignored.
    @(posedge clk); #1;
    mret_i = 1'b1;
    @(posedge clk); #1;
    mret_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_ignored_mret", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
    end

    // Interrupt withdrawn while draining: back to idle, no writes.
    mstatus_i    = 32'h8;
    mie_i        = 32'h800;
    mip_i        = 32'h800;
    pipe_empty_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("stall_before_drop", 32'(stall_o), 32'd1);
    mip_i = '0;
    @(posedge clk); #1;
    checkOutput("stall_after_drop", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("stall_idle_after_drop", 32'(stall_o), 32'd0);
    checkOutput("in_handler_after_drop", 32'(in_handler_o), 32'd0);

    // Vectored-mode mtvec value.
    applyStimulus(32'h8, 32'h800, 32'h800, 32'h1001, 32'h300, 0, 1);
    applyMret(32'h1880, 32'h300, 0);

    // Pipeline never drains: timeout path.
    applyStimulus(32'h8, 32'h800, 32'h800, 32'h2000, 32'h408, -1, 0);
    applyMret(32'h1880, 32'h408, 1);

    // Reset in the middle of the entry sequence.
    @(posedge clk); #1;
    mstatus_i    = 32'h8;
    mie_i        = 32'h800;
    mip_i        = 32'h800;
    mtvec_i      = 32'h3000;
    resume_pc_i  = 32'h500;
    pipe_empty_i = 1'b1;
    expWr.push_back('{12'h341, 32'h500});
    expWr.push_back('{12'h342, 32'h8000_000B});
    expWr.push_back('{12'h300, trapEntryStatus(32'h8)});
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      @(posedge clk); #1;
      if (csr_we_o && csr_waddr_o == 12'h342) hit = 1;
    end
    if (hit == 0) reportFail("save_cause_not_reached", 32'd0, 32'd1);
    rst = 1'b1;
    #1 checkResetOutputs("midreset");
    expWr.delete();
    expRedir.delete();
    errSticky = 0;
    mip_i        = '0;
    pipe_empty_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("stall_after_midreset", 32'(stall_o), 32'd0);

    // Fresh entry after the abort starts from idle again.
    applyStimulus(32'h88, 32'h800, 32'h800, 32'h4000, 32'h604, 1, 0);
    applyMret(32'h1880, 32'h604, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
Name: trap_seq

Overview:
- Machine-mode trap sequencer between the CSR file and the core pipeline.
- Detects an enabled external interrupt (mstatus.MIE, mie.MEIE, mip.MEIP), stalls and drains the pipeline, and writes mepc, mcause and mstatus through the single CSR write port. It then redirects fetch to the mtvec target.
- On mret it restores mstatus and redirects fetch to mepc.
- Owns all trap-related CSR writes; the pipeline owns none.

Parameters:
- XLEN, 32, CSR/data width.
- ALEN, 32, fetch address width (≤ XLEN).
- DRAIN_TIMEOUT, 15, max drain cycles before error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mstatus_i  in  XLEN  current mstatus
- mie_i  in  XLEN  current mie
- mip_i  in  XLEN  current mip
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- resume_pc_i  in  ALEN  PC of oldest uncommitted instruction
- pipe_empty_i  in  1  no instruction in flight past fetch
- mret_i  in  1  one-cycle pulse: mret committed
- stall_o  out  1  freeze fetch/issue
- flush_o  out  1  one-cycle kill of fetch stage
- redir_valid_o  out  1  redirect request
- redir_pc_o  out  ALEN  redirect target
- redir_ready_i  in  1  fetch accepts redirect
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR address
- csr_wdata_o  out  XLEN  CSR write data
- in_handler_o  out  1  trap being serviced
- drain_err_o  out  1  sticky: drain timeout hit

Behaviour:
- Reset (async, rst=1): state IDLE, drain counter 0, and all outputs 0.
- irq_take = mstatus_i[3] & mie_i[11] & mip_i[11].
- State IDLE:
  - irq_take=1 and in_handler=0 → DRAIN; stall_o=1 from the next cycle.
  - mret_i=1 while in_handler=1 → RESTORE.
  - mret_i=1 while in_handler=0 is ignored; no state change.
  - mret_i and irq_take in the same cycle: mret wins.
- State DRAIN:
  - stall_o=1 and the counter increments.
  - pipe_empty_i=1 → latch resume_pc_i into epc_q, go to SAVE_EPC.
  - Counter reaches DRAIN_TIMEOUT (nonzero) → set drain_err_o, latch resume_pc_i anyway, go to SAVE_EPC.
  - irq_take dropping during DRAIN → return to IDLE, stall_o released next cycle, no CSR writes.
- State SAVE_EPC (1 cycle): csr_we_o=1, addr 0x341, data = zero-extended epc_q with bits[1:0] cleared.
- State SAVE_CAUSE (1 cycle): csr_we_o=1, addr 0x342, data = {1'b1, 31'd11}.
- State SAVE_STAT (1 cycle): csr_we_o=1, addr 0x300, data = mstatus_i with MPIE(7) = MIE(3), MIE(3) = 0, MPP[12:11] = 2'b11.
- State REDIR:
  - stall_o=1, redir_valid_o=1, redir_pc_o = {mtvec_i[ALEN-1:2], 2'b00}.
  - redir_valid_o and redir_pc_o hold stable until redir_ready_i.
  - On the accepting cycle: flush_o=1 for that cycle, in_handler=1, next state IDLE.
  - stall_o drops the cycle after acceptance.
- State RESTORE:
  - stall_o=1.
  - Single-cycle write: csr_we_o=1, addr 0x300, data = mstatus_i with MIE = MPIE, MPIE = 1.
  - Then → RET.
- State RET:
  - redir_valid_o=1, redir_pc_o = mepc_i[ALEN-1:0] with bits[1:0] cleared; same hold rule as REDIR.
  - On acceptance: flush_o=1, in_handler=0, next state IDLE.
- Only one CSR write per cycle; csr_we_o=0 in all other states.
- Nesting is not supported: irq_take is ignored while in_handler=1.
- Latency, irq_take to first CSR write = 2 + drain cycles. Total entry ≥ 5 cycles.
- Reset mid-sequence aborts immediately. Partial CSR writes are not undone; the CSR file is reset by the same rst.

Optional Feature:
- Macro: TRAP_SEQ_VECTORED_EN.
- Defined: when mtvec_i[1:0]==2'b01, REDIR target = base + (11<<2), i.e. {mtvec_i[ALEN-1:2], 2'b00} + 44. Any other mode value uses base only.
- Undefined: the mode bits are ignored and the target is always the base.

Decomposition:
- csr_pkg holds shared constants:
  - CSR addresses: CSR_MSTATUS=0x300, CSR_MIE=0x304, CSR_MTVEC=0x305, CSR_MEPC=0x341, CSR_MCAUSE=0x342, CSR_MIP=0x344.
  - Bit indices: MSTATUS_MIE=3, MSTATUS_MPIE=7, MIE_MEIE=11, MIP_MEIP=11.
  - CAUSE_M_EXT=11.
  - The trap_state_e enum.
- Sub-module trap_drain_timer: counter with clear/enable/expire output.

Test Plan:
- mstatus=0x8, mie=0x800, mip=0x800, mtvec=0x1000, pipe_empty after 3 cycles, resume_pc=0x204 → writes 0x341=0x204, 0x342=0x8000000B, 0x300=0x1880 in consecutive cycles; redir_pc=0x1000; in_handler=1.
- redir_ready_i held low 4 cycles in REDIR → redir_valid_o and redir_pc_o stable for all 4 cycles; flush_o pulses exactly once, on acceptance.
- mret_i after entry with mepc=0x204, mstatus=0x1880 → writes 0x300=0x1888; redir_pc=0x204; in_handler=0.
- mip drops to 0 in DRAIN → return to IDLE, no CSR writes, stall released next cycle.
- pipe_empty_i never asserted → drain_err_o=1 after 15 cycles; entry sequence completes.
- With TRAP_SEQ_VECTORED_EN defined and mtvec=0x1001 → redir_pc=0x102C.
- rst asserted in SAVE_CAUSE → all outputs 0 asynchronously; state IDLE.
